// File: rtl/cla_pkg.sv
// Shared state encoding for the carry-lookahead burst accumulator.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit adder with fully expanded lookahead carries; purely combinational.
// o_result[WIDTH] is the carry-out, no carry-in.
module carry_lookahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             term;

  assign gen  = i_add1 & i_add2;
  assign prop = i_add1 ^ i_add2;

  // carry[i+1] = OR over j<=i of gen[j] & prop[j+1..i], each term flat rather than rippled
  always_comb begin
    carry = '0;
    term  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        carry[i+1] = carry[i+1] | term;
      end
    end
  end

  assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_accumulator.sv
// Accumulates COUNT unsigned operands per burst with a sticky carry flag; result valid the cycle
// after the last transfer and held in DONE until i_ready (o_ready low outside ACCUM).
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   add_res;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
    .i_add1   (acc_q),
    .i_add2   (i_data),
    .o_result (add_res)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // previous result stays visible until a new burst actually starts
        if (i_start) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        o_ready = 1'b1;
        if (i_valid) begin
          acc_d = add_res[WIDTH-1:0];
          ovf_d = ovf_q | add_res[WIDTH];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_sum      = acc_q;
  assign o_overflow = ovf_q;

endmodule
